nibble_serial_adder_ctrl: RTL and testbench

- Sequencing controller that performs a WIDTH-bit add or subtract by time-multiplexing one instance of the team's 4-bit lookahead adder (binary_adder_lookahead), one nibble per clock.
- The carry is chained between nibbles in a register.
- Sits between a requester using a start/ready/done handshake and the shared 4-bit adder datapath.
- Trades latency for area, for wide operands in low-throughput paths.

---
 rtl/nibble_serial_adder_ctrl.sv | 155 +++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract built from one shared 4-bit lookahead adder.
// One nibble is processed per clock; the carry is chained through a register.

// 4-bit carry-lookahead adder slice; s_c[4] is the carry out.
module binary_adder_lookahead (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] s_c
);

  logic [3:0] g_c;
  logic [3:0] p_c;
  logic [4:0] c_c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g_c    = a & b;
    p_c    = a ^ b;
    c_c[0] = cin;
    c_c[1] = g_c[0] | (p_c[0] & cin);
    c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & cin);
    c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
           | (p_c[2] & p_c[1] & p_c[0] & cin);
    c_c[4] = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
           | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
           | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & cin);
    s_c    = {c_c[4], p_c ^ c_c[3:0]};
  end

endmodule

// Sequencer that walks the operands one nibble per cycle through the adder.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    res_r;

  logic [IDXW+1:0] base_c;
  logic [3:0]      nib_a_c;
  logic [3:0]      nib_b_c;
  logic [4:0]      add_s_c;
  logic            last_c;
  logic [W-1:0]    res_c;
  logic            ovf_c;

  // Select the current nibble and merge the adder result into the partial sum.
  always_comb begin
    base_c  = {idx, 2'b00};
    nib_a_c = a_r[base_c +: 4];
    nib_b_c = b_r[base_c +: 4];
    last_c  = (idx == IDXW'(NIBBLES - 1));
    res_c   = res_r;
    res_c[base_c +: 4] = add_s_c[3:0];
    // Final nibble holds the result MSB; b_r is already inverted for subtract.
    ovf_c   = (a_r[W-1] == b_r[W-1]) && (add_s_c[3] != a_r[W-1]);
  end

  binary_adder_lookahead u_add (
    .a   (nib_a_c),
    .b   (nib_b_c),
    .cin (carry),
    .s_c (add_s_c)
  );

  // Control FSM, operand/partial-sum registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_r <= res_c;
          carry <= add_s_c[4];
          if (last_c) begin
            // Wrap idx so it never leaves the legal nibble range.
            idx   <= '0;
            sum   <= res_c;
            cout  <= add_s_c[4];
            ovf   <= ovf_c;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          idx   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized checks for nibble_serial_adder_ctrl at 2, 4 and 8 nibbles.
module tb_nibble_serial_adder_ctrl;

  logic clk;
  logic rst;

  logic        start4, sub4, ready4, busy4, done4, cout4, ovf4;
  logic [15:0] a4, b4, sum4;
  logic        start2, sub2, ready2, busy2, done2, cout2, ovf2;
  logic [7:0]  a2, b2, sum2;
  logic        start8, sub8, ready8, busy8, done8, cout8, ovf8;
  logic [31:0] a8, b8, sum8;

  int          n_cmp;
  int          n_bad;
  logic [15:0] prev4;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit operation on the 4-nibble instance, starting from IDLE.
  task automatic op4(input string tag, input logic s, input logic [15:0] av,
                     input logic [15:0] bv, input logic [15:0] es,
                     input logic ec, input logic eo);
    int cyc;
    int rlow;
    check({tag, "/ready_in"}, 64'(ready4), 64'(1));
    start4 = 1'b1; sub4 = s; a4 = av; b4 = bv;
    tick();
    start4 = 1'b0; sub4 = ~s; a4 = ~av; b4 = ~bv;
    cyc  = 1;
    rlow = 0;
    check({tag, "/hold"}, 64'(sum4), 64'(prev4));
    while (!done4 && cyc < 20) begin
      if (!ready4) rlow++;
      tick();
      cyc++;
    end
    if (!ready4) rlow++;
    check({tag, "/latency"}, 64'(cyc), 64'(5));
    check({tag, "/sum"}, 64'(sum4), 64'(es));
    check({tag, "/cout"}, 64'(cout4), 64'(ec));
    check({tag, "/ovf"}, 64'(ovf4), 64'(eo));
    check({tag, "/busy"}, 64'(busy4), 64'(1));
    tick();
    check({tag, "/done_pulse"}, 64'(done4), 64'(0));
    check({tag, "/ready_out"}, 64'(ready4), 64'(1));
    check({tag, "/ready_low"}, 64'(rlow), 64'(5));
    prev4 = es;
  endtask

  initial begin
    int cyc;
    int nd;
    n_cmp = 0; n_bad = 0; prev4 = '0;
    start4 = 0; sub4 = 0; a4 = '0; b4 = '0;
    start2 = 0; sub2 = 0; a2 = '0; b2 = '0;
    start8 = 0; sub8 = 0; a8 = '0; b8 = '0;
    rst = 1'b1;
    #1;
    check("rst/ready", 64'(ready4), 64'(1));
    check("rst/busy", 64'(busy4), 64'(0));
    check("rst/done", 64'(done4), 64'(0));
    check("rst/sum", 64'(sum4), 64'(0));
    check("rst/cout_ovf", 64'({cout4, ovf4}), 64'(0));
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst/ready", 64'({ready2, ready4, ready8}), 64'(7));

    op4("add1", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    op4("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    op4("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    op4("sub_borrow", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);

    // Start held high with operands changing while busy.
    start4 = 1'b1; sub4 = 1'b0; a4 = 16'h0001; b4 = 16'h0001;
    tick();
    cyc = 1;
    while (!done4 && cyc < 20) begin
      a4 = 16'($urandom); b4 = 16'($urandom); sub4 = 1'b1;
      tick();
      cyc++;
    end
    check("hold/latency", 64'(cyc), 64'(5));
    check("hold/sum", 64'(sum4), 64'(16'h0002));
    check("hold/cout", 64'(cout4), 64'(0));
    a4 = 16'h0003; b4 = 16'h0004; sub4 = 1'b0;
    tick();
    check("hold/idle_done", 64'(done4), 64'(0));
    check("hold/idle_ready", 64'(ready4), 64'(1));
    check("hold/idle_busy", 64'(busy4), 64'(0));
    tick();
    start4 = 1'b0;
    check("hold/restart", 64'(ready4), 64'(0));
    cyc = 1;
    while (!done4 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("hold/2nd_latency", 64'(cyc), 64'(5));
    check("hold/2nd_sum", 64'(sum4), 64'(16'h0007));
    tick();
    prev4 = 16'h0007;

    op4("sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // Reset during the second RUN cycle aborts the operation.
    start4 = 1'b1; sub4 = 1'b0; a4 = 16'hAAAA; b4 = 16'h5555;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort/ready", 64'(ready4), 64'(1));
    check("abort/busy", 64'(busy4), 64'(0));
    check("abort/done", 64'(done4), 64'(0));
    check("abort/sum", 64'(sum4), 64'(0));
    check("abort/cout_ovf", 64'({cout4, ovf4}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) nd++;
      tick();
    end
    check("abort/no_done", 64'(nd), 64'(0));
    prev4 = '0;
    op4("after_abort", 1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);

    // Back-to-back randomized operations, 2 nibbles.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] av, bv;
      logic       s, eo;
      logic [8:0] full;
      int         c2;
      av = 8'($urandom); bv = 8'($urandom); s = 1'($urandom);
      if (i % 8 == 0) bv = s ? av : ~av;
      full = s ? ({1'b0, av} + {1'b0, ~bv} + 9'd1) : ({1'b0, av} + {1'b0, bv});
      eo = s ? ((av[7] != bv[7]) && (full[7] != av[7]))
             : ((av[7] == bv[7]) && (full[7] != av[7]));
      start2 = 1'b1; sub2 = s; a2 = av; b2 = bv;
      tick();
      start2 = 1'b0; a2 = ~av; b2 = ~bv;
      c2 = 1;
      while (!done2 && c2 < 40) begin
        tick();
        c2++;
      end
      check("r2/latency", 64'(c2), 64'(3));
      check("r2/sum", 64'(sum2), 64'(full[7:0]));
      check("r2/cout", 64'(cout2), 64'(full[8]));
      check("r2/ovf", 64'(ovf2), 64'(eo));
      tick();
    end

    // Back-to-back randomized operations, 8 nibbles.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] av, bv;
      logic        s, eo;
      logic [32:0] full;
      int          c8;
      av = $urandom; bv = $urandom; s = 1'($urandom);
      if (i % 8 == 0) bv = s ? av : ~av;
      if (i % 8 == 1) begin av = 32'h7FFF_FFFF; bv = s ? 32'hFFFF_FFFF : 32'h0000_0001; end
      full = s ? ({1'b0, av} + {1'b0, ~bv} + 33'd1) : ({1'b0, av} + {1'b0, bv});
      eo = s ? ((av[31] != bv[31]) && (full[31] != av[31]))
             : ((av[31] == bv[31]) && (full[31] != av[31]));
      start8 = 1'b1; sub8 = s; a8 = av; b8 = bv;
      tick();
      start8 = 1'b0; a8 = ~av; b8 = ~bv;
      c8 = 1;
      while (!done8 && c8 < 40) begin
        tick();
        c8++;
      end
      check("r8/latency", 64'(c8), 64'(9));
      check("r8/sum", 64'(sum8), 64'(full[31:0]));
      check("r8/cout", 64'(cout8), 64'(full[32]));
      check("r8/ovf", 64'(ovf8), 64'(eo));
      check("r8/busy", 64'({busy8, busy2}), 64'(2));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
